// File: rtl/qua_lsp_relspe_ctrl_pkg.sv
// Shared definitions for the Qua_Lsp search sequencer (G.729 Relspe2).
// Holds bus widths, the step and FSM state encodings, the candidate scratch address,
// the LSPCB1 table base and small helpers used by the controller.
package qua_lsp_relspe_ctrl_pkg;

  localparam int unsigned ModeN  = 2;   // MA modes swept (mode port is 1 bit wide)
  localparam int unsigned NChild = 5;   // child steps
  localparam int unsigned AddrW  = 11;  // scratch-memory address width
  localparam int unsigned DataW  = 32;  // scratch-memory data width

  localparam logic [AddrW-1:0] CandAddr   = 11'h000;  // pre_select candidate word
  localparam logic [11:0]      Lspcb1Base = 12'h400;  // LSPCB1 table, 16 words/entry

  typedef enum logic [2:0] {
    StepPresel  = 3'd0,
    StepSel1    = 3'd1,
    StepSel2    = 3'd2,
    StepTdist   = 3'd3,
    StepLastsel = 3'd4
  } step_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StKick   = 3'd1,
    StWait   = 3'd2,
    StFetchA = 3'd3,
    StFetchD = 3'd4,
    StNext   = 3'd5,
    StFin    = 3'd6
  } state_e;

  function automatic logic [NChild-1:0] step_onehot(input step_e s);
    logic [NChild-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

  // 12-bit sum, wraps by construction.
  function automatic logic [11:0] lspcb1_addr(input logic [6:0] cand);
    return Lspcb1Base + {1'b0, cand, 4'b0000};
  endfunction

endpackage

// File: rtl/qua_lsp_relspe_ctrl_if.sv
// Bus bundle between the Qua_Lsp sequencer and its environment.
//   start/done         : run request and one-cycle completion pulse
//   mode               : current MA mode to the children
//   child_start/done   : per-child start pulse and completion
//   lspcb1_addr        : LSPCB1 entry address for lsp_select_1
//   child_*            : per-child scratch-memory buses (child k at slice k)
//   mem_*              : shared scratch-memory port
//   test_*             : bench override of the memory port (QUA_LSP_TEST_MUX_EN only)
// Modports: slave = the sequencer, master = the environment driving it.
interface qua_lsp_relspe_ctrl_if;
  import qua_lsp_relspe_ctrl_pkg::*;

  logic                    start;
  logic                    done;
  logic                    mode;
  logic [NChild-1:0]       child_start;
  logic [NChild-1:0]       child_done;
  logic [11:0]             lspcb1_addr;
  logic [NChild*AddrW-1:0] child_read_addr;
  logic [NChild*AddrW-1:0] child_write_addr;
  logic [NChild*DataW-1:0] child_mem_out;
  logic [NChild-1:0]       child_write_en;
  logic [AddrW-1:0]        mem_read_addr;
  logic [AddrW-1:0]        mem_write_addr;
  logic [DataW-1:0]        mem_out;
  logic                    mem_write_en;
  logic [DataW-1:0]        mem_in;

`ifdef QUA_LSP_TEST_MUX_EN
  logic                    test_mux_sel;
  logic [AddrW-1:0]        test_read_addr;
  logic [AddrW-1:0]        test_write_addr;
  logic [DataW-1:0]        test_mem_out;
  logic                    test_write_en;

  modport slave (
    input  start, child_done, child_read_addr, child_write_addr, child_mem_out,
           child_write_en, mem_in, test_mux_sel, test_read_addr, test_write_addr,
           test_mem_out, test_write_en,
    output done, mode, child_start, lspcb1_addr, mem_read_addr, mem_write_addr,
           mem_out, mem_write_en
  );
  modport master (
    output start, child_done, child_read_addr, child_write_addr, child_mem_out,
           child_write_en, mem_in, test_mux_sel, test_read_addr, test_write_addr,
           test_mem_out, test_write_en,
    input  done, mode, child_start, lspcb1_addr, mem_read_addr, mem_write_addr,
           mem_out, mem_write_en
  );
`else
  modport slave (
    input  start, child_done, child_read_addr, child_write_addr, child_mem_out,
           child_write_en, mem_in,
    output done, mode, child_start, lspcb1_addr, mem_read_addr, mem_write_addr,
           mem_out, mem_write_en
  );
  modport master (
    output start, child_done, child_read_addr, child_write_addr, child_mem_out,
           child_write_en, mem_in,
    input  done, mode, child_start, lspcb1_addr, mem_read_addr, mem_write_addr,
           mem_out, mem_write_en
  );
`endif

endinterface

// File: rtl/qua_lsp_mem_mux.sv
// Scratch-memory port mux: one-hot select of a child bus, with a controller read
// override and (QUA_LSP_TEST_MUX_EN) a test override that beats everything.
// Ports:
//   sel_i            one-hot active child, all zero when no child owns the port
//   ctrl_rd_en_i     controller drives the read address (candidate fetch)
//   ctrl_rd_addr_i   controller read address
//   child_*_i        packed per-child buses
//   test_*_i         test override (QUA_LSP_TEST_MUX_EN only)
//   mem_*_o          shared scratch-memory port; all zero when nobody owns it
module qua_lsp_mem_mux
  import qua_lsp_relspe_ctrl_pkg::*;
(
  input  logic [NChild-1:0]       sel_i,
  input  logic                    ctrl_rd_en_i,
  input  logic [AddrW-1:0]        ctrl_rd_addr_i,
  input  logic [NChild*AddrW-1:0] child_read_addr_i,
  input  logic [NChild*AddrW-1:0] child_write_addr_i,
  input  logic [NChild*DataW-1:0] child_mem_out_i,
  input  logic [NChild-1:0]       child_write_en_i,
`ifdef QUA_LSP_TEST_MUX_EN
  input  logic                    test_mux_sel_i,
  input  logic [AddrW-1:0]        test_read_addr_i,
  input  logic [AddrW-1:0]        test_write_addr_i,
  input  logic [DataW-1:0]        test_mem_out_i,
  input  logic                    test_write_en_i,
`endif
  output logic [AddrW-1:0]        mem_read_addr_o,
  output logic [AddrW-1:0]        mem_write_addr_o,
  output logic [DataW-1:0]        mem_out_o,
  output logic                    mem_write_en_o
);

  always_comb begin
    mem_read_addr_o  = '0;
    mem_write_addr_o = '0;
    mem_out_o        = '0;
    mem_write_en_o   = 1'b0;
    // AND-OR mux; an all-zero select leaves the port idle.
    for (int k = 0; k < NChild; k++) begin
      if (sel_i[k]) begin
        mem_read_addr_o  |= child_read_addr_i[k*AddrW +: AddrW];
        mem_write_addr_o |= child_write_addr_i[k*AddrW +: AddrW];
        mem_out_o        |= child_mem_out_i[k*DataW +: DataW];
        mem_write_en_o   |= child_write_en_i[k];
      end
    end
    if (ctrl_rd_en_i) begin
      mem_read_addr_o = ctrl_rd_addr_i;
    end
`ifdef QUA_LSP_TEST_MUX_EN
    if (test_mux_sel_i) begin
      mem_read_addr_o  = test_read_addr_i;
      mem_write_addr_o = test_write_addr_i;
      mem_out_o        = test_mem_out_i;
      mem_write_en_o   = test_write_en_i;
    end
`endif
  end

endmodule

// File: rtl/qua_lsp_relspe_ctrl.sv
// Qua_Lsp search sequencer (G.729 Relspe2). For each MA mode runs pre_select,
// select_1, select_2 and get_tdist, then last_select once. After pre_select it
// fetches the candidate from scratch memory and forms the LSPCB1 entry address.
// Owns the shared scratch-memory port and grants it to the child in its WAIT phase.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset; aborts a run without a done pulse
//   bus     qua_lsp_relspe_ctrl_if.slave (start/done, child handshakes, mem port)
// Build option: QUA_LSP_TEST_MUX_EN adds a test override of the memory port.
module qua_lsp_relspe_ctrl
  import qua_lsp_relspe_ctrl_pkg::*;
(
  input logic                  clk_i,
  input logic                  rst_ni,
  qua_lsp_relspe_ctrl_if.slave bus
);

  state_e            state_q;
  step_e             step_q;
  logic              mode_q;
  logic              done_q;
  logic [NChild-1:0] child_start_q;
  logic [11:0]       lspcb1_addr_q;

  // child_start_q is loaded on entry to KICK so the pulse lines up with that state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      step_q        <= StepPresel;
      mode_q        <= 1'b0;
      done_q        <= 1'b0;
      child_start_q <= '0;
      lspcb1_addr_q <= Lspcb1Base;
    end else begin
      done_q        <= 1'b0;
      child_start_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q       <= StKick;
            mode_q        <= 1'b0;
            step_q        <= StepPresel;
            child_start_q <= step_onehot(StepPresel);
          end
        end
        StKick: state_q <= StWait;
        StWait: begin
          if (bus.child_done[step_q]) begin
            state_q <= (step_q == StepPresel) ? StFetchA : StNext;
          end
        end
        StFetchA: state_q <= StFetchD;
        StFetchD: begin
          lspcb1_addr_q <= lspcb1_addr(bus.mem_in[6:0]);
          state_q       <= StNext;
        end
        StNext: begin
          if (step_q == StepLastsel) begin
            state_q <= StFin;
            done_q  <= 1'b1;
          end else if (step_q != StepTdist) begin
            state_q       <= StKick;
            step_q        <= step_e'(step_q + 3'd1);
            child_start_q <= step_onehot(step_e'(step_q + 3'd1));
          end else if (mode_q != 1'(ModeN - 1)) begin
            state_q       <= StKick;
            mode_q        <= mode_q + 1'b1;
            step_q        <= StepPresel;
            child_start_q <= step_onehot(StepPresel);
          end else begin
            state_q       <= StKick;
            step_q        <= StepLastsel;
            child_start_q <= step_onehot(StepLastsel);
          end
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [NChild-1:0] wait_sel;
  logic              fetch_rd;

  assign wait_sel = (state_q == StWait) ? step_onehot(step_q) : '0;
  assign fetch_rd = (state_q == StFetchA);

  qua_lsp_mem_mux u_mem_mux (
    .sel_i              (wait_sel),
    .ctrl_rd_en_i       (fetch_rd),
    .ctrl_rd_addr_i     (CandAddr),
    .child_read_addr_i  (bus.child_read_addr),
    .child_write_addr_i (bus.child_write_addr),
    .child_mem_out_i    (bus.child_mem_out),
    .child_write_en_i   (bus.child_write_en),
`ifdef QUA_LSP_TEST_MUX_EN
    .test_mux_sel_i     (bus.test_mux_sel),
    .test_read_addr_i   (bus.test_read_addr),
    .test_write_addr_i  (bus.test_write_addr),
    .test_mem_out_i     (bus.test_mem_out),
    .test_write_en_i    (bus.test_write_en),
`endif
    .mem_read_addr_o    (bus.mem_read_addr),
    .mem_write_addr_o   (bus.mem_write_addr),
    .mem_out_o          (bus.mem_out),
    .mem_write_en_o     (bus.mem_write_en)
  );

  assign bus.done        = done_q;
  assign bus.mode        = mode_q;
  assign bus.child_start = child_start_q;
  assign bus.lspcb1_addr = lspcb1_addr_q;

endmodule

// File: tb/tb_qua_lsp_relspe_ctrl.sv
// Bench for qua_lsp_relspe_ctrl: table of hand-computed runs, randomized runs checked
// cycle by cycle against a timeline model built from step latencies, and a reset abort.
module tb_qua_lsp_relspe_ctrl;
  import qua_lsp_relspe_ctrl_pkg::*;

  localparam int MaxT = 160;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qua_lsp_relspe_ctrl_if bus_if ();
  qua_lsp_relspe_ctrl dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus_if));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Child models: done pulses lat[i] cycles after the i-th start pulse of the run.
  int                lat [9];
  int                act_idx = 0;
  int                cnt [NChild];
  logic              new_run = 1'b0;
  logic [NChild-1:0] spur    = '0;

  always @(posedge clk) begin
    if (new_run) begin
      act_idx <= 0;
      for (int k = 0; k < NChild; k++) cnt[k] <= 0;
    end else begin
      for (int k = 0; k < NChild; k++) begin
        if (bus_if.child_start[k]) cnt[k] <= (act_idx < 9) ? lat[act_idx] : 1;
        else if (cnt[k] > 0)       cnt[k] <= cnt[k] - 1;
      end
      if (|bus_if.child_start) act_idx <= act_idx + 1;
    end
  end

  always_comb begin
    bus_if.child_done = spur;
    for (int k = 0; k < NChild; k++) begin
      if (cnt[k] == 1) bus_if.child_done[k] = 1'b1;
    end
  end

  // Scratch memory with one-cycle read latency.
  logic [31:0] mem [2048];
  always @(posedge clk) bus_if.mem_in <= mem[bus_if.mem_read_addr];

  task automatic drive_children(input bit fixed);
    for (int k = 0; k < NChild; k++) begin
      bus_if.child_read_addr[k*11 +: 11]  = 11'($urandom);
      bus_if.child_write_addr[k*11 +: 11] = 11'($urandom);
      bus_if.child_mem_out[k*32 +: 32]    = $urandom;
      bus_if.child_write_en[k]            = 1'($urandom);
    end
    if (fixed) begin
      bus_if.child_write_addr[2*11 +: 11] = 11'h123;
      bus_if.child_mem_out[2*32 +: 32]    = 32'h0000_BEEF;
      bus_if.child_write_en[2]            = 1'b1;
      bus_if.child_write_addr[1*11 +: 11] = 11'h7FF;
      bus_if.child_write_en[1]            = 1'b1;
    end
  endtask

  // Expected timeline, cycle 1 = first cycle after the start cycle.
  logic [NChild-1:0] e_cs    [MaxT];
  bit                e_done  [MaxT];
  bit                e_mode  [MaxT];
  bit                e_fetch [MaxT];
  logic [11:0]       e_lsp   [MaxT];
  int                e_act   [MaxT];
  logic [11:0]       ref_lsp = 12'h400;

  // Each step instance: 1 kick cycle, lat waiting cycles, 2 fetch cycles after
  // pre_select, 1 advance cycle; then the done cycle.
  task automatic build_model(input logic [31:0] m0, input logic [31:0] m1,
                             output int fin_t, output int sw_t);
    int t = 1;
    int step;
    int m;
    logic [11:0] lsp = ref_lsp;
    logic [31:0] mv;
    for (int i = 0; i < MaxT; i++) begin
      e_cs[i] = '0; e_done[i] = 0; e_mode[i] = 1; e_fetch[i] = 0;
      e_lsp[i] = ref_lsp; e_act[i] = -1;
    end
    sw_t = 0;
    for (int i = 0; i < 9; i++) begin
      step = (i == 8) ? 4 : i % 4;
      m    = (i < 4) ? 0 : 1;
      e_cs[t][step] = 1'b1; e_mode[t] = (m == 1); e_lsp[t] = lsp; t++;
      for (int w = 0; w < lat[i]; w++) begin
        e_act[t] = step; e_mode[t] = (m == 1); e_lsp[t] = lsp; t++;
      end
      if (step == 0) begin
        e_fetch[t] = 1; e_mode[t] = (m == 1); e_lsp[t] = lsp; t++;
        e_mode[t] = (m == 1); e_lsp[t] = lsp; t++;
        mv  = (m == 0) ? m0 : m1;
        lsp = 12'((1024 + (mv % 128) * 16) % 4096);
      end
      if (i == 0) sw_t = t;
      e_mode[t] = (m == 1); e_lsp[t] = lsp; t++;
    end
    e_done[t] = 1; e_mode[t] = 1; e_lsp[t] = lsp;
    fin_t = t;
    e_mode[t+1] = 1; e_lsp[t+1] = lsp;
    ref_lsp = lsp;
  endtask

  task automatic run(input logic [31:0] m0, input logic [31:0] m1, input bit fixed,
                     input bit noise, input int abort_step,
                     output int fin_t, output int fin_seen);
    int sw_t;
    int k;
    logic [54:0] x_mem;
    build_model(m0, m1, fin_t, sw_t);
    fin_seen = -1;
    mem[CandAddr] = m0;
    @(posedge clk); #1;
    new_run = 1'b1; bus_if.start = 1'b1; spur = '0;
    drive_children(fixed);
    for (int t = 1; t <= fin_t + 1; t++) begin
      @(posedge clk); #1;
      new_run = 1'b0;
      if (t > fin_t)   bus_if.start = 1'b0;
      else if (noise)  bus_if.start = ($urandom_range(0, 3) == 0);
      else             bus_if.start = fixed && (e_act[t] == 1);
      if (t == sw_t) mem[CandAddr] = m1;
      if (noise)      spur = NChild'($urandom);
      else if (fixed) spur = (e_act[t] == 1) ? 5'b10000 : 5'b00000;
      else            spur = '0;
      if (e_act[t] >= 0) spur[e_act[t]] = 1'b0;
      drive_children(fixed);
      if (abort_step >= 0 && e_act[t] == abort_step) begin
        rst_n = 1'b0;
        #1;
        chk("abort_done", bus_if.done, 0);
        chk("abort_cs", bus_if.child_start, 0);
        chk("abort_we", bus_if.mem_write_en, 0);
        chk("abort_lsp", bus_if.lspcb1_addr, 12'h400);
        chk("abort_mode", bus_if.mode, 0);
        ref_lsp = 12'h400;
        return;
      end
      #1;
      if (bus_if.done === 1'b1 && fin_seen < 0) fin_seen = t;
      chk("child_start", bus_if.child_start, e_cs[t]);
      chk("done", bus_if.done, e_done[t]);
      chk("mode", bus_if.mode, e_mode[t]);
      chk("lspcb1_addr", bus_if.lspcb1_addr, e_lsp[t]);
      if (e_act[t] >= 0) begin
        k = e_act[t];
        x_mem = {bus_if.child_read_addr[k*11 +: 11], bus_if.child_write_addr[k*11 +: 11],
                 bus_if.child_mem_out[k*32 +: 32], bus_if.child_write_en[k]};
      end else if (e_fetch[t]) begin
        x_mem = {CandAddr, 11'h0, 32'h0, 1'b0};
      end else begin
        x_mem = '0;
      end
      chk("mem_port", {bus_if.mem_read_addr, bus_if.mem_write_addr, bus_if.mem_out,
                       bus_if.mem_write_en}, x_mem);
      if (fixed && e_act[t] == 2) begin
        chk("c2_wr_addr", bus_if.mem_write_addr, 11'h123);
        chk("c2_wr_data", bus_if.mem_out, 32'h0000_BEEF);
        chk("c2_wr_en", bus_if.mem_write_en, 1);
      end
    end
    bus_if.start = 1'b0;
  endtask

  typedef struct packed {
    logic [8:0][3:0] l;
    logic [31:0]     m0;
    logic [31:0]     m1;
    logic            fixed;
    logic [7:0]      fin_exp;
    logic [11:0]     lsp_exp;
  } vec_t;

  vec_t vecs [4];

  task automatic run_vec(input vec_t v);
    int fin_t;
    int fin_seen;
    for (int i = 0; i < 9; i++) lat[i] = int'(v.l[i]);
    run(v.m0, v.m1, v.fixed, 1'b0, -1, fin_t, fin_seen);
    chk("fin_cycle", fin_seen, v.fin_exp);
    chk("lsp_end", bus_if.lspcb1_addr, v.lsp_exp);
  endtask

  initial begin
    int fin_t;
    int fin_seen;
    vecs[0] = '{l: {9{4'd3}}, m0: 32'd80, m1: 32'd80, fixed: 1'b1,
                fin_exp: 8'd50, lsp_exp: 12'h900};
    vecs[1] = '{l: {9{4'd3}}, m0: 32'd80, m1: 32'd72, fixed: 1'b0,
                fin_exp: 8'd50, lsp_exp: 12'h880};
    vecs[2] = '{l: {9{4'd1}}, m0: 32'd0, m1: 32'd127, fixed: 1'b0,
                fin_exp: 8'd32, lsp_exp: 12'hBF0};
    vecs[3] = '{l: {4'd4, 4'd3, 4'd2, 4'd1, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1},
                m0: 32'hFFFF_FF90, m1: 32'h0000_0085, fixed: 1'b0,
                fin_exp: 8'd48, lsp_exp: 12'h450};

    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    bus_if.start = 1'b0;
    bus_if.child_read_addr  = '0;
    bus_if.child_write_addr = '0;
    bus_if.child_mem_out    = '0;
    bus_if.child_write_en   = '0;
`ifdef QUA_LSP_TEST_MUX_EN
    bus_if.test_mux_sel    = 1'b0;
    bus_if.test_read_addr  = '0;
    bus_if.test_write_addr = '0;
    bus_if.test_mem_out    = '0;
    bus_if.test_write_en   = 1'b0;
`endif

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", bus_if.done, 0);
    chk("rst_cs", bus_if.child_start, 0);
    chk("rst_we", bus_if.mem_write_en, 0);
    chk("rst_lsp", bus_if.lspcb1_addr, 12'h400);
    chk("rst_mode", bus_if.mode, 0);
    chk("rst_mem", {bus_if.mem_read_addr, bus_if.mem_write_addr, bus_if.mem_out}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_cs", bus_if.child_start, 0);
    ref_lsp = 12'h400;

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Randomized runs with stray starts and stray child done bits.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 9; i++) lat[i] = $urandom_range(1, 6);
      run($urandom, $urandom, 1'b0, 1'b1, -1, fin_t, fin_seen);
      chk("rand_fin_cycle", fin_seen, fin_t);
    end

    // Reset during step 2 wait, then a complete run.
    for (int i = 0; i < 9; i++) lat[i] = 3;
    run(32'd80, 32'd80, 1'b0, 1'b0, 2, fin_t, fin_seen);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_abort_done", bus_if.done, 0);
      chk("post_abort_cs", bus_if.child_start, 0);
    end
    run_vec(vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
